dna_fifo_sched: RTL
===================

DNA_FIFO_SCHED -- requirements
Module: dna_fifo_sched

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of all data paths.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  leave IDLE, enter RUN.
- stop  in  1  leave RUN, enter DRAIN.
- cfg_depth  in  8  usable entries; 0 or >128 is treated as 128.
- req0_valid / req1_valid  in  1  writer N offers data.
- req0_data / req1_data  in  DATA_WIDTH  writer N data.
- req0_ready / req1_ready  out  1  writer N accepted this cycle.
- rd_req  in  1  consumer requests one entry.
- rd_valid  out  1  rd_data holds a popped entry.
- rd_data  out  DATA_WIDTH  popped entry.
- fifo_en, fifo_wr, fifo_rd  out  1  FIFO storage controls.
- fifo_w_data  out  DATA_WIDTH  FIFO write data.
- fifo_r_data  in  DATA_WIDTH  FIFO head entry, combinational from the FIFO.
- fifo_last  out  7  highest FIFO address in use, equal to depth_lat-1.
- count  out  8  current occupancy.
- full, empty  out  1  status flags.
- state  out  2  IDLE=0, RUN=1, DRAIN=2.

Function
REQ-003 In IDLE, start SHALL latch the clamped cfg_depth into depth_lat and move to RUN on the next edge; stop is ignored.
REQ-004 In RUN, stop SHALL move to DRAIN on the next edge; start is ignored.
REQ-005 In DRAIN, writes SHALL be blocked; start is ignored.
REQ-006 DRAIN SHALL move to IDLE on the first edge where count==0, including when count is already 0 on entry.
REQ-007 In RUN, when only one reqN_valid is high, that writer SHALL be granted.
REQ-008 In RUN, when both reqN_valid are high, the writer not granted last SHALL be granted; last_grant updates only on an accepted write.
REQ-009 reqN_ready SHALL be combinational: (state==RUN) & !full & grant==N & reqN_valid.
REQ-010 At most one ready SHALL be high per cycle.
REQ-011 On an accepted write, fifo_wr SHALL be 1 and fifo_w_data SHALL equal the granted writer's data in the same cycle.
REQ-012 A read SHALL occur when rd_req & !empty and state is RUN or DRAIN; fifo_rd SHALL be 1 and fifo_r_data SHALL be registered into rd_data.
REQ-013 rd_valid SHALL be 1 for exactly the cycle after each read; rd_req while empty or in IDLE SHALL be ignored, with no fifo_rd.
REQ-014 fifo_en SHALL equal fifo_wr | fifo_rd; all three SHALL be 0 in IDLE.
REQ-015 count SHALL update as: +1 on write only, -1 on read only, unchanged on simultaneous read and write.
REQ-016 count SHALL never exceed depth_lat and never go below 0.
REQ-017 full SHALL equal (count==depth_lat); empty SHALL equal (count==0).
REQ-018 When full, a simultaneous read SHALL NOT enable a write in the same cycle.
REQ-019 rd_data SHALL hold its value when no read occurs.

Reset
REQ-020 While reset is high, the block SHALL force: state=IDLE, count=0, depth_lat=128, last_grant=1 (so req0 wins the first tie), rd_valid=0, rd_data=0, all ready and fifo_* control outputs 0, empty=1, full=0.
REQ-021 Reset asserted mid-RUN or mid-DRAIN SHALL abort immediately; in-flight rd_valid SHALL be dropped.
REQ-022 The FIFO storage SHALL share the same reset so that its pointers realign with count=0.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Reset, start with cfg_depth=4, req0 writes 0x11,0x22,0x33,0x44 -> full=1, count=4, fifo_last=3, req0_ready=0 on the 5th attempt.
- Both writers valid continuously, req0=0xA0, req1=0xB0, depth 8 -> grants alternate req0,req1,req0,...; 8 accepted; FIFO holds A0,B0,A0,B0,...
- count=2 in RUN, writer valid and rd_req in the same cycle -> count stays 2; rd_valid=1 next cycle with the oldest data.
- Write 3 entries, pulse stop, hold rd_req -> no further writes accepted; 3 reads; state returns to IDLE on the edge where count hits 0.
- rd_req in IDLE and while empty in RUN -> fifo_rd=0, rd_valid stays 0; cfg_depth=0 -> depth_lat=128, fifo_last=127.
- Reset asserted while count=5 in RUN -> next cycle state=IDLE, count=0, empty=1, rd_valid=0.

Source files
------------

// File: rtl/dna_fifo_sched.sv
//-----------------------------------------------------------------------------
// dna_fifo_sched
//
// Two-writer / one-reader scheduler in front of an external FIFO storage
// block. Writers 0 and 1 are arbitrated round-robin on ties. The consumer
// pops one entry per rd_req. A small IDLE/RUN/DRAIN sequencer gates which
// operations are allowed. Occupancy and the active depth are tracked here,
// so the storage only needs pointers that wrap at fifo_last.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   start, stop          sequencer controls
//   cfg_depth            requested depth, 0 or >128 means 128
//   reqN_valid/data      writer N offer
//   reqN_ready           writer N accepted this cycle (combinational)
//   rd_req               consumer pop request
//   rd_valid, rd_data    popped entry, valid the cycle after the pop
//   fifo_en/wr/rd        storage strobes
//   fifo_w_data          storage write data
//   fifo_r_data          storage head entry (combinational from storage)
//   fifo_last            highest storage address in use
//   count, full, empty   occupancy status
//   state                IDLE=0, RUN=1, DRAIN=2
//
// state | meaning
// IDLE  | inactive, waiting for start; depth may be reconfigured
// RUN   | writes and reads allowed
// DRAIN | writes blocked, reads allowed until empty
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module dna_fifo_sched #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [7:0]            cfg_depth,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req0_ready,
    output logic                  req1_ready,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_en,
    output logic                  fifo_wr,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] fifo_w_data,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic [6:0]            fifo_last,
    output logic [7:0]            count,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    // Depth is held as depth-1 so all 128 depths fit in 7 bits and
    // fifo_last comes straight from the register.
    logic [6:0]            r_last;
    logic [7:0]            r_count;
    logic                  r_last_grant;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [6:0]            w_last_cfg;
    logic [7:0]            w_depth;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_run;
    logic                  w_grant;
    logic                  w_wr0;
    logic                  w_wr1;
    logic                  w_wr;
    logic                  w_rd;

    // cfg_depth of 0 or above 128 selects the full 128 entries.
    assign w_last_cfg = ((cfg_depth == 8'd0) || (cfg_depth > 8'd128))
                        ? 7'd127 : (cfg_depth[6:0] - 7'd1);

    assign w_depth = {1'b0, r_last} + 8'd1;
    assign w_full  = (r_count == w_depth);
    assign w_empty = (r_count == 8'd0);
    assign w_run   = (r_state == ST_RUN);

    // Single requester wins outright; on a tie the writer not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // !full alone blocks writes, so a pop while full never frees a slot
    // for a write in the same cycle.
    assign w_wr0 = w_run & ~w_full & ~w_grant & req0_valid;
    assign w_wr1 = w_run & ~w_full &  w_grant & req1_valid;
    assign w_wr  = w_wr0 | w_wr1;
    assign w_rd  = rd_req & ~w_empty & ((r_state == ST_RUN) || (r_state == ST_DRAIN));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 7'd127;
        end else if ((r_state == ST_IDLE) && start) begin
            r_last <= w_last_cfg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 8'd1;
                2'b01:   r_count <= r_count - 8'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset value 1 lets writer 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_wr) begin
            r_last_grant <= w_wr1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= fifo_r_data;
            end
        end
    end

    assign req0_ready  = w_wr0;
    assign req1_ready  = w_wr1;
    assign fifo_wr     = w_wr;
    assign fifo_rd     = w_rd;
    assign fifo_en     = w_wr | w_rd;
    assign fifo_w_data = w_wr1 ? req1_data : req0_data;
    assign fifo_last   = r_last;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign state       = r_state;

endmodule
